// File: rtl/mips_state_sequencer_if.sv
// Control-path bundle between the multicycle core and its state sequencer.
// master: core side (drives run enable, IR opcode, memory ready).
// slave : sequencer side (drives state vector and status flags).
interface mips_state_sequencer_if;
  logic       enable;
  logic [5:0] opcode;
  logic       mem_ready;
  logic [3:0] state;
  logic       instr_done;
  logic       halted;
  logic       illegal;

  modport master (
    output enable, opcode, mem_ready,
    input  state, instr_done, halted, illegal
  );

  modport slave (
    input  enable, opcode, mem_ready,
    output state, instr_done, halted, illegal
  );
endinterface

// File: rtl/mips_state_sequencer.sv
// Multicycle MIPS main state register and next-state logic.
// Optional feature macro: ILLEGAL_OPCODE_TRAP_EN -- when defined, an unlisted
// opcode in DECODE traps to HALT and sets the sticky `illegal` flag; when not
// defined, unlisted opcodes retire as NOPs and `illegal` is tied low.
module mips_state_sequencer (
  input  logic                  clk,
  input  logic                  rstb,
  mips_state_sequencer_if.slave bus
);

  typedef enum logic [3:0] {
    FETCH            = 4'd0,
    READ_FROM_MEMORY = 4'd1,
    DECODE           = 4'd2,
    EXECUTE          = 4'd3,
    ALU_WRITEBACK    = 4'd4,
    MEM_ADDR         = 4'd5,
    MEM_READ         = 4'd6,
    MEM_WRITEBACK    = 4'd7,
    MEM_WRITE        = 4'd8,
    BRANCH           = 4'd9,
    JUMP             = 4'd10,
    I_EXECUTE        = 4'd11,
    I_WRITEBACK      = 4'd12,
    HALT             = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  state_t state_q;
  logic   instr_done_q;
`ifdef ILLEGAL_OPCODE_TRAP_EN
  logic   illegal_q;
`endif

  // State register with registered retire pulse; enable low freezes everything.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q      <= FETCH;
      instr_done_q <= 1'b0;
`ifdef ILLEGAL_OPCODE_TRAP_EN
      illegal_q    <= 1'b0;
`endif
    end else if (bus.enable) begin
      instr_done_q <= 1'b0;
      case (state_q)
        FETCH:            state_q <= READ_FROM_MEMORY;
        READ_FROM_MEMORY: if (bus.mem_ready) state_q <= DECODE;
        DECODE: begin
          case (bus.opcode)
            OP_RTYPE:                         state_q <= EXECUTE;
            OP_LW, OP_SW:                     state_q <= MEM_ADDR;
            OP_BEQ, OP_BNE:                   state_q <= BRANCH;
            OP_J:                             state_q <= JUMP;
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: state_q <= I_EXECUTE;
            OP_HALT:                          state_q <= HALT;
            default: begin
`ifdef ILLEGAL_OPCODE_TRAP_EN
              state_q   <= HALT;
              illegal_q <= 1'b1;
`else
              state_q      <= FETCH;
              instr_done_q <= 1'b1;
`endif
            end
          endcase
        end
        EXECUTE:          state_q <= ALU_WRITEBACK;
        I_EXECUTE:        state_q <= I_WRITEBACK;
        MEM_ADDR:         state_q <= (bus.opcode == OP_LW) ? MEM_READ : MEM_WRITE;
        MEM_READ:         if (bus.mem_ready) state_q <= MEM_WRITEBACK;
        MEM_WRITE: begin
          if (bus.mem_ready) begin
            state_q      <= FETCH;
            instr_done_q <= 1'b1;
          end
        end
        ALU_WRITEBACK, I_WRITEBACK, MEM_WRITEBACK, BRANCH, JUMP: begin
          state_q      <= FETCH;
          instr_done_q <= 1'b1;
        end
        HALT:             state_q <= HALT;
        // Unused codes 13/14 recover to FETCH without retiring anything.
        default:          state_q <= FETCH;
      endcase
    end
  end

  assign bus.state      = state_q;
  assign bus.instr_done = instr_done_q;
  assign bus.halted     = (state_q == HALT);
`ifdef ILLEGAL_OPCODE_TRAP_EN
  assign bus.illegal    = illegal_q;
`else
  assign bus.illegal    = 1'b0;
`endif

endmodule

// File: tb/tb_mips_state_sequencer.sv
// Self-checking bench for mips_state_sequencer: directed scenarios plus
// randomized instruction streams checked against a per-opcode path model.
module tb_mips_state_sequencer;

  logic clk;
  logic rstb;
  mips_state_sequencer_if bus();

  mips_state_sequencer dut (
    .clk  (clk),
    .rstb (rstb),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned cycle    = 0;
  logic [3:0]  path[$];
  logic        ill_exp  = 1'b0;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  // Expected observable vector {state, instr_done, halted, illegal}.
  function automatic logic [6:0] pack(input logic [3:0] s, input logic d, input logic il);
    return {s, d, (s == 4'd15), il};
  endfunction

  function automatic bit is_listed(input logic [5:0] op);
    return op inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02,
                      6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h3F};
  endfunction

  // Per-instruction state route starting at FETCH; leaving the last entry
  // returns to FETCH with a retire pulse, unless the route ends in HALT.
  function automatic void build_path(input logic [5:0] op);
    path.delete();
    path.push_back(4'd0); path.push_back(4'd1); path.push_back(4'd2);
    case (op)
      6'h00: begin path.push_back(4'd3); path.push_back(4'd4); end
      6'h23: begin path.push_back(4'd5); path.push_back(4'd6); path.push_back(4'd7); end
      6'h2B: begin path.push_back(4'd5); path.push_back(4'd8); end
      6'h04, 6'h05: path.push_back(4'd9);
      6'h02: path.push_back(4'd10);
      6'h08, 6'h0A, 6'h0C, 6'h0D: begin path.push_back(4'd11); path.push_back(4'd12); end
      6'h3F: path.push_back(4'd15);
      default: begin
`ifdef ILLEGAL_OPCODE_TRAP_EN
        path.push_back(4'd15);
`endif
      end
    endcase
  endfunction

  task automatic drive(input logic en, input logic rdy, input logic [5:0] op);
    bus.enable    = en;
    bus.mem_ready = rdy;
    bus.opcode    = op;
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic do_reset();
    bus.enable    = 1'b1;
    bus.mem_ready = 1'b0;
    bus.opcode    = 6'h00;
    rstb          = 1'b0;
    ill_exp       = 1'b0;
    @(posedge clk);
    #1;
    rstb = 1'b1;
  endtask

  task automatic test_reset();
    bus.enable = 1'b1; bus.mem_ready = 1'b1; bus.opcode = 6'h00;
    rstb = 1'b0;
    #3;
    n_checks++;
    if ({bus.state, bus.instr_done, bus.halted, bus.illegal} !== pack(4'd0, 1'b0, 1'b0))
      $display("FAIL reset_hold: got %b expected %b",
               {bus.state, bus.instr_done, bus.halted, bus.illegal}, pack(4'd0, 1'b0, 1'b0));
    else n_pass++;
    repeat (2) @(posedge clk);
    #1;
    rstb = 1'b1;
    #1;
    n_checks++;
    if ({bus.state, bus.instr_done, bus.halted, bus.illegal} !== pack(4'd0, 1'b0, 1'b0))
      $display("FAIL reset_release: got %b expected %b",
               {bus.state, bus.instr_done, bus.halted, bus.illegal}, pack(4'd0, 1'b0, 1'b0));
    else n_pass++;
  endtask

  task automatic test_rtype();
    logic [3:0] exp_s[5] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 6'h00);
      n_checks++;
      if ({bus.state, bus.instr_done, bus.halted, bus.illegal} !== pack(exp_s[i], i == 4, 1'b0))
        $display("FAIL rtype step %0d: got %b expected %b", i,
                 {bus.state, bus.instr_done, bus.halted, bus.illegal}, pack(exp_s[i], i == 4, 1'b0));
      else n_pass++;
    end
  endtask

  task automatic test_lw_stall();
    logic [3:0] exp_s[8] = '{4'd1, 4'd2, 4'd5, 4'd6, 4'd6, 4'd6, 4'd7, 4'd0};
    logic       rdy_s[8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    int unsigned pulses = 0;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, rdy_s[i], 6'h23);
      if (bus.instr_done) pulses++;
      n_checks++;
      if ({bus.state, bus.instr_done, bus.halted, bus.illegal} !== pack(exp_s[i], i == 7, 1'b0))
        $display("FAIL lw_stall step %0d: got %b expected %b", i,
                 {bus.state, bus.instr_done, bus.halted, bus.illegal}, pack(exp_s[i], i == 7, 1'b0));
      else n_pass++;
    end
    n_checks++;
    if (pulses !== 1) $display("FAIL lw_pulses: got %0d expected 1", pulses);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [5:0]  ops[3] = '{6'h2B, 6'h04, 6'h02};
    int unsigned done_at[$];
    int unsigned start;
    do_reset();
    start = cycle;
    foreach (ops[k]) begin
      build_path(ops[k]);
      for (int i = 0; i < path.size(); i++) begin
        logic [3:0] nxt;
        nxt = (i + 1 < path.size()) ? path[i+1] : 4'd0;
        drive(1'b1, 1'b1, ops[k]);
        if (bus.instr_done) done_at.push_back(cycle - start);
        n_checks++;
        if ({bus.state, bus.instr_done, bus.halted, bus.illegal} !== pack(nxt, i + 1 == path.size(), 1'b0))
          $display("FAIL b2b op %h step %0d: got %b expected %b", ops[k], i,
                   {bus.state, bus.instr_done, bus.halted, bus.illegal},
                   pack(nxt, i + 1 == path.size(), 1'b0));
        else n_pass++;
      end
    end
    n_checks++;
    if (done_at.size() != 3 || done_at[0] != 5 || done_at[1] != 9 || done_at[2] != 13)
      $display("FAIL b2b_spacing: got %0d pulses first at %0d expected 3 pulses at 5,9,13",
               done_at.size(), (done_at.size() > 0) ? done_at[0] : 0);
    else n_pass++;
  endtask

  task automatic test_enable_hold();
    logic [3:0] exp_s[8] = '{4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd4, 4'd0};
    logic       en_s[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(en_s[i], 1'b1, 6'h00);
      n_checks++;
      if ({bus.state, bus.instr_done, bus.halted, bus.illegal} !== pack(exp_s[i], i == 7, 1'b0))
        $display("FAIL enable_hold step %0d: got %b expected %b", i,
                 {bus.state, bus.instr_done, bus.halted, bus.illegal}, pack(exp_s[i], i == 7, 1'b0));
      else n_pass++;
    end
  endtask

  task automatic test_random(input int unsigned n_instr);
    logic [5:0] legal[10] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02,
                              6'h08, 6'h0A, 6'h0C, 6'h0D};
    logic       done_exp = 1'b0;
    do_reset();
    for (int unsigned k = 0; k < n_instr; k++) begin
      logic [5:0] op;
      op = legal[$urandom_range(0, 9)];
`ifndef ILLEGAL_OPCODE_TRAP_EN
      if ($urandom_range(0, 7) == 0) begin
        for (int t = 0; t < 64; t++) begin
          op = 6'($urandom_range(0, 63));
          if (!is_listed(op)) break;
        end
        if (is_listed(op)) op = 6'h3E;
      end
`endif
      build_path(op);
      for (int i = 0; i < path.size(); i++) begin
        logic [3:0] s, nxt, exp_s;
        bit         moved;
        s     = path[i];
        nxt   = (i + 1 < path.size()) ? path[i+1] : 4'd0;
        moved = 1'b0;
        for (int g = 0; g < 60 && !moved; g++) begin
          logic       en, rdy;
          logic [5:0] opd;
          en  = ($urandom_range(0, 4) != 0);
          rdy = ($urandom_range(0, 2) != 0);
          opd = (s == 4'd2 || s == 4'd5) ? op : 6'($urandom_range(0, 63));
          drive(en, rdy, opd);
          if (!en) begin
            exp_s = s;
          end else if ((s inside {4'd1, 4'd6, 4'd8}) && !rdy) begin
            exp_s    = s;
            done_exp = 1'b0;
          end else begin
            exp_s    = nxt;
            done_exp = (i + 1 == path.size());
            moved    = 1'b1;
          end
          n_checks++;
          if ({bus.state, bus.instr_done, bus.halted, bus.illegal} !== pack(exp_s, done_exp, 1'b0))
            $display("FAIL random instr %0d op %h cycle %0d: got %b expected %b", k, op, cycle,
                     {bus.state, bus.instr_done, bus.halted, bus.illegal}, pack(exp_s, done_exp, 1'b0));
          else n_pass++;
        end
      end
    end
  endtask

  task automatic test_illegal();
    do_reset();
    drive(1'b1, 1'b1, 6'h3E);
    drive(1'b1, 1'b1, 6'h3E);
    n_checks++;
    if (bus.state !== 4'd2) $display("FAIL illegal_reach_decode: got %0d expected 2", bus.state);
    else n_pass++;
    drive(1'b1, 1'b1, 6'h3E);
`ifdef ILLEGAL_OPCODE_TRAP_EN
    ill_exp = 1'b1;
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if ({bus.state, bus.instr_done, bus.halted, bus.illegal} !== pack(4'd15, 1'b0, ill_exp))
        $display("FAIL illegal_trap hold %0d: got %b expected %b", i,
                 {bus.state, bus.instr_done, bus.halted, bus.illegal}, pack(4'd15, 1'b0, ill_exp));
      else n_pass++;
      drive(1'b1, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)));
    end
    #2;
    rstb    = 1'b0;
    ill_exp = 1'b0;
    #1;
    n_checks++;
    if ({bus.state, bus.instr_done, bus.halted, bus.illegal} !== pack(4'd0, 1'b0, ill_exp))
      $display("FAIL illegal_clear_by_reset: got %b expected %b",
               {bus.state, bus.instr_done, bus.halted, bus.illegal}, pack(4'd0, 1'b0, ill_exp));
    else n_pass++;
    @(posedge clk);
    #1;
    rstb = 1'b1;
`else
    n_checks++;
    if ({bus.state, bus.instr_done, bus.halted, bus.illegal} !== pack(4'd0, 1'b1, 1'b0))
      $display("FAIL illegal_nop: got %b expected %b",
               {bus.state, bus.instr_done, bus.halted, bus.illegal}, pack(4'd0, 1'b1, 1'b0));
    else n_pass++;
`endif
  endtask

  task automatic test_reset_mid_stall();
    logic [3:0] exp_s[6] = '{4'd1, 4'd2, 4'd5, 4'd6, 4'd6, 4'd6};
    logic       rdy_s[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, rdy_s[i], 6'h23);
      n_checks++;
      if (bus.state !== exp_s[i])
        $display("FAIL mid_stall step %0d: got %0d expected %0d", i, bus.state, exp_s[i]);
      else n_pass++;
    end
    #2;
    rstb = 1'b0;
    #1;
    n_checks++;
    if ({bus.state, bus.instr_done, bus.halted, bus.illegal} !== pack(4'd0, 1'b0, 1'b0))
      $display("FAIL reset_in_stall: got %b expected %b",
               {bus.state, bus.instr_done, bus.halted, bus.illegal}, pack(4'd0, 1'b0, 1'b0));
    else n_pass++;
    @(posedge clk);
    #1;
    rstb = 1'b1;
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 6'h04);
    n_checks++;
    if (bus.instr_done !== 1'b1) $display("FAIL beq_retire: got %b expected 1", bus.instr_done);
    else n_pass++;
    #2;
    rstb = 1'b0;
    #1;
    n_checks++;
    if ({bus.state, bus.instr_done} !== {4'd0, 1'b0})
      $display("FAIL reset_cancels_done: got %b expected %b", {bus.state, bus.instr_done}, {4'd0, 1'b0});
    else n_pass++;
    @(posedge clk);
    #1;
    rstb = 1'b1;
  endtask

  task automatic test_halt();
    logic [3:0] exp_s[3] = '{4'd1, 4'd2, 4'd15};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 6'h3F);
      n_checks++;
      if ({bus.state, bus.instr_done, bus.halted, bus.illegal} !== pack(exp_s[i], 1'b0, 1'b0))
        $display("FAIL halt_entry step %0d: got %b expected %b", i,
                 {bus.state, bus.instr_done, bus.halted, bus.illegal}, pack(exp_s[i], 1'b0, 1'b0));
      else n_pass++;
    end
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'(i % 2), 6'($urandom_range(0, 63)));
      n_checks++;
      if ({bus.state, bus.instr_done, bus.halted, bus.illegal} !== pack(4'd15, 1'b0, 1'b0))
        $display("FAIL halt_hold %0d: got %b expected %b", i,
                 {bus.state, bus.instr_done, bus.halted, bus.illegal}, pack(4'd15, 1'b0, 1'b0));
      else n_pass++;
    end
    #2;
    rstb = 1'b0;
    #1;
    n_checks++;
    if ({bus.state, bus.instr_done, bus.halted, bus.illegal} !== pack(4'd0, 1'b0, 1'b0))
      $display("FAIL halt_exit_reset: got %b expected %b",
               {bus.state, bus.instr_done, bus.halted, bus.illegal}, pack(4'd0, 1'b0, 1'b0));
    else n_pass++;
    @(posedge clk);
    #1;
    rstb = 1'b1;
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_stall();
    test_back_to_back();
    test_enable_hold();
    test_random(60);
    test_illegal();
    test_reset_mid_stall();
    test_halt();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mips_state_sequencer.md
# mips_state_sequencer

Main state register and next-state logic for the multicycle MIPS core. Produces the 4-bit `state` vector that the combinational control decoder turns into pc_write/ir_write/reg_write/ALU/memory strobes. It advances through the per-instruction state sequence, selects the sequence from the IR opcode, stalls on memory, and reports instruction completion and halt.

## Interface
- No parameters. State encodings are fixed and shared with the control decoder through the common defines header.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rstb`  in  1  asynchronous, active-low reset.
- `enable`  in  1  core run enable; when low, all registers hold their values.
- `opcode`  in  6  IR[31:26]; sampled only in DECODE and MEM_ADDR.
- `mem_ready`  in  1  memory has completed the current access.
- `state`  out  4  current state, registered.
- `instr_done`  out  1  registered one-cycle pulse on the first FETCH cycle after an instruction retires.
- `halted`  out  1  high while `state` is HALT.
- `illegal`  out  1  sticky illegal-opcode flag. Driven 0 unless ILLEGAL_OPCODE_TRAP_EN is defined.

## Operation
- State encodings: FETCH=0, READ_FROM_MEMORY=1, DECODE=2, EXECUTE=3, ALU_WRITEBACK=4, MEM_ADDR=5, MEM_READ=6, MEM_WRITEBACK=7, MEM_WRITE=8, BRANCH=9, JUMP=10, I_EXECUTE=11, I_WRITEBACK=12, HALT=15. Codes 13 and 14 are unused.
- FETCH always goes to READ_FROM_MEMORY.
- READ_FROM_MEMORY:
  - `mem_ready`=0: stay; the IR is reloaded every cycle.
  - `mem_ready`=1: go to DECODE.
- DECODE, by opcode:
  - 0x00 → EXECUTE
  - 0x23 (lw) or 0x2B (sw) → MEM_ADDR
  - 0x04 (beq) or 0x05 (bne) → BRANCH
  - 0x02 (j) → JUMP
  - 0x08, 0x0A, 0x0C, 0x0D (addi/slti/andi/ori) → I_EXECUTE
  - 0x3F → HALT
  - any other opcode → see Configuration.
- EXECUTE → ALU_WRITEBACK → FETCH.
- I_EXECUTE → I_WRITEBACK → FETCH.
- MEM_ADDR: opcode 0x23 → MEM_READ; otherwise → MEM_WRITE.
- MEM_READ: stay while `mem_ready`=0; when `mem_ready`=1 → MEM_WRITEBACK → FETCH.
- MEM_WRITE: stay while `mem_ready`=0; when `mem_ready`=1 → FETCH.
- BRANCH → FETCH. JUMP → FETCH.
- HALT is terminal; only `rstb` exits it.
- An instruction retires on the transition into FETCH from ALU_WRITEBACK, I_WRITEBACK, MEM_WRITEBACK, MEM_WRITE (with `mem_ready`=1), BRANCH or JUMP. `instr_done` is registered high for exactly that one cycle.
- An unused code in the state register (13 or 14) → FETCH on the next enabled edge. No `instr_done` is generated.
- `enable`=0 freezes `state`, `instr_done` and `illegal`. It takes priority over `mem_ready`.

## Timing
- Reset values, applied asynchronously while `rstb`=0: `state`=FETCH, `instr_done`=0, `illegal`=0.
- `halted` is combinational from `state`, so it is 0 during reset.
- First FETCH cycle is the first rising edge after `rstb` deasserts. No `instr_done` on that cycle.
- Latency in cycles, FETCH to the next FETCH, with `mem_ready`=1 and `enable`=1:
  - R-type 5, I-type 5
  - lw 6, sw 5
  - branch 4, jump 4
- Each cycle with `mem_ready`=0 in a wait state (READ_FROM_MEMORY, MEM_READ, MEM_WRITE) adds exactly one cycle.
- Each cycle with `enable`=0 adds exactly one cycle, in any state.
- `mem_ready` is sampled only in wait states. It is ignored elsewhere; a pulse during FETCH is not remembered.
- Reset asserted mid-instruction, including during a memory stall: `state` returns to FETCH immediately, and any pending `instr_done` pulse is cancelled.

## Configuration
- Macro: `ILLEGAL_OPCODE_TRAP_EN`.
- Defined: an unlisted opcode in DECODE → HALT, and `illegal` is set to 1 on the same edge. `illegal` is cleared only by reset.
- Not defined: an unlisted opcode in DECODE → FETCH, with an `instr_done` pulse (treated as a NOP, 3 cycles). `illegal` is tied to 0.

## Test plan
- Reset, then opcode 0x00 with `mem_ready`=1:
  - `state` sequence 0,1,2,3,4,0.
  - `instr_done`=1 only on the second FETCH.
- lw (0x23):
  - `mem_ready` low for 2 cycles in MEM_READ → sequence 0,1,2,5,6,6,6,7,0 (9 cycles).
  - `instr_done` pulses once.
- sw (0x2B), then beq (0x04), then j (0x02), all with `mem_ready`=1:
  - sequences 0,1,2,5,8 | 0,1,2,9 | 0,1,2,10 | 0.
  - three `instr_done` pulses, spaced 5, 4 and 4 cycles apart.
- Opcode 0x3F:
  - reaches 15, `halted`=1, and stays there 20 cycles with `mem_ready` toggling.
  - `rstb` pulse → `state`=0 asynchronously.
- Opcode 0x3E:
  - with the macro: `state` 2→15 and `illegal`=1, held until reset.
  - without the macro: 2→0, `instr_done`=1, `illegal`=0.
- Stall and reset corners:
  - `enable`=0 for 3 cycles in EXECUTE → `state` holds 3, then resumes to 4.
  - `rstb` asserted in MEM_READ mid-stall → `state`=0 and `instr_done`=0 before the next edge.
